// File: rtl/f1_lights_ctrl.sv
// ---------------------------------------------------------------------------
// f1_lights_ctrl -- start-light sequencer with reaction timer.
//
// On a trigger the lights fill one per tick until all N_LIGHTS are lit. They
// then hold for a pseudo-random 1..127 ticks taken from a free-running 7-bit
// LFSR. After that they all go out, and the block counts clk cycles until the
// driver presses react.
//
// Optional feature: define F1_FALSE_START_EN to treat react during FILL/HOLD
// as a false start. Without the macro that react is ignored and false_start
// stays 0.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   tick         one-cycle step strobe
//   trigger      start request pulse (acted on only in IDLE)
//   react        driver button pulse
//   data_out     light pattern, bit i drives light i
//   busy         high whenever the sequencer is not idle
//   react_time   captured reaction time in clk cycles, held until next capture
//   react_valid  one-cycle pulse when react_time updates
//   false_start  one-cycle pulse on react before lights-out
// ---------------------------------------------------------------------------
module f1_lights_ctrl #(
    parameter int unsigned N_LIGHTS = 8,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                trigger,
    input  logic                react,
    output logic [N_LIGHTS-1:0] data_out,
    output logic                busy,
    output logic [CNT_W-1:0]    react_time,
    output logic                react_valid,
    output logic                false_start
);

`ifdef F1_FALSE_START_EN
    localparam bit FalseStartEn = 1'b1;
`else
    localparam bit FalseStartEn = 1'b0;
`endif

    localparam int unsigned LightCntW = $clog2(N_LIGHTS + 1);
    localparam logic [LightCntW-1:0] LightsFull = LightCntW'(N_LIGHTS);
    localparam logic [LightCntW-1:0] LightsLast = LightCntW'(N_LIGHTS - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StFill = 2'd1;
    localparam logic [1:0] StHold = 2'd2;
    localparam logic [1:0] StGo   = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [LightCntW-1:0] light_cnt_q, light_cnt_d;
    logic [6:0]           delay_q, delay_d;
    logic [6:0]           lfsr_q, lfsr_d;
    logic [CNT_W-1:0]     react_cnt_q, react_cnt_d;
    logic [N_LIGHTS-1:0]  data_out_q, data_out_d;
    logic                 busy_q, busy_d;
    logic [CNT_W-1:0]     react_time_q, react_time_d;
    logic                 react_valid_q, react_valid_d;
    logic                 false_start_q, false_start_d;

    logic                 tick_eff;
    logic                 false_hit;
    logic [N_LIGHTS-1:0]  fill_pattern;

    // Next-state logic.
    always_comb begin
        // x^7 + x^6 + 1, maximal length: the all-zero state is never reached.
        lfsr_d        = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
        // A react in the same cycle as a tick takes priority; the tick is lost.
        tick_eff      = tick & ~react;
        false_hit     = FalseStartEn & react;

        state_d       = state_q;
        light_cnt_d   = light_cnt_q;
        delay_d       = delay_q;
        react_cnt_d   = react_cnt_q;
        react_time_d  = react_time_q;
        react_valid_d = 1'b0;
        false_start_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (trigger) begin
                    state_d     = StFill;
                    light_cnt_d = '0;
                end
            end
            StFill: begin
                if (false_hit) begin
                    state_d       = StIdle;
                    false_start_d = 1'b1;
                end else if (tick_eff) begin
                    if (light_cnt_q == LightsLast) begin
                        state_d     = StHold;
                        light_cnt_d = LightsFull;
                        delay_d     = lfsr_q;
                    end else begin
                        light_cnt_d = light_cnt_q + LightCntW'(1);
                    end
                end
            end
            StHold: begin
                if (false_hit) begin
                    state_d       = StIdle;
                    false_start_d = 1'b1;
                end else if (tick_eff) begin
                    // The loaded delay is never zero, so <= 1 is the last tick.
                    if (delay_q <= 7'd1) begin
                        state_d     = StGo;
                        delay_d     = '0;
                        react_cnt_d = '0;
                    end else begin
                        delay_d = delay_q - 7'd1;
                    end
                end
            end
            StGo: begin
                if (react) begin
                    state_d       = StIdle;
                    react_time_d  = react_cnt_q;
                    react_valid_d = 1'b1;
                end else if (react_cnt_q != {CNT_W{1'b1}}) begin
                    react_cnt_d = react_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        for (int unsigned i = 0; i < N_LIGHTS; i++) begin
            fill_pattern[i] = (i < 32'(light_cnt_d));
        end

        // Outputs are registered from the next state, so they line up with state_q.
        case (state_d)
            StFill:  data_out_d = fill_pattern;
            StHold:  data_out_d = {N_LIGHTS{1'b1}};
            default: data_out_d = '0;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            light_cnt_q   <= '0;
            delay_q       <= '0;
            lfsr_q        <= 7'h01;
            react_cnt_q   <= '0;
            data_out_q    <= '0;
            busy_q        <= 1'b0;
            react_time_q  <= '0;
            react_valid_q <= 1'b0;
            false_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            light_cnt_q   <= light_cnt_d;
            delay_q       <= delay_d;
            lfsr_q        <= lfsr_d;
            react_cnt_q   <= react_cnt_d;
            data_out_q    <= data_out_d;
            busy_q        <= busy_d;
            react_time_q  <= react_time_d;
            react_valid_q <= react_valid_d;
            false_start_q <= false_start_d;
        end
    end

    assign data_out    = data_out_q;
    assign busy        = busy_q;
    assign react_time  = react_time_q;
    assign react_valid = react_valid_q;
    assign false_start = false_start_q;

endmodule

// File: doc/f1_lights_ctrl.md
F1_LIGHTS_CTRL -- requirements
Module: f1_lights_ctrl

Interface
REQ-001 Parameter N_LIGHTS, default 8: number of start lights; legal range 1..32.
REQ-002 Parameter CNT_W, default 16: width of the reaction-time counter; legal range 4..32.
REQ-003 clk  input  1: clock; all state changes on its rising edge.
REQ-004 rst  input  1: reset, asynchronous, active-high.
REQ-005 tick  input  1: one-cycle step strobe from the tick generator; sampled only when clk rises.
REQ-006 trigger  input  1: start request, one-cycle pulse, synchronous to clk.
REQ-007 react  input  1: driver button pulse, synchronous to clk.
REQ-008 data_out  output  N_LIGHTS: light pattern; bit i drives light i.
REQ-009 busy  output  1: high in every state except IDLE.
REQ-010 react_time  output  CNT_W: clk cycles from lights-out to react; held until the next capture.
REQ-011 react_valid  output  1: one-cycle pulse when react_time updates.
REQ-012 false_start  output  1: one-cycle pulse on react before lights-out.

Function
REQ-013 FSM states: IDLE, FILL, HOLD, GO; state is registered, encoding is free.
REQ-014 IDLE: data_out = 0; trigger -> FILL with light count = 0.
REQ-015 FILL: data_out = count ones right-justified (count 3 -> ...0111); each tick increments count.
REQ-016 FILL -> HOLD on the tick that makes count = N_LIGHTS (data_out all ones); delay counter loads the current LFSR value.
REQ-017 LFSR: 7-bit, taps x^7+x^6+1, shifts every clk in all states, never reaches zero; the HOLD delay is therefore 1..127 ticks.
REQ-018 HOLD: data_out all ones; each tick decrements the delay counter; the tick that makes it 0 -> GO.
REQ-019 GO: data_out = 0; reaction counter clears on entry, then increments every clk, saturating at all ones (no wrap).
REQ-020 GO + react -> react_time = counter value in that cycle, react_valid = 1 for one cycle, -> IDLE.
REQ-021 A GO react in the first GO cycle captures react_time = 0.
REQ-022 trigger is ignored outside IDLE; trigger and react together in IDLE -> FILL, react ignored.
REQ-023 tick and react in the same cycle: react wins and tick is ignored.
REQ-024 Outputs are registered; react_valid and false_start assert the cycle after the causing input.

Reset
REQ-025 rst -> state IDLE, data_out = 0, busy = 0, react_time = 0, react_valid = 0, false_start = 0, LFSR = 7'h01, all counters = 0.
REQ-026 rst mid-sequence (FILL/HOLD/GO) aborts immediately and asynchronously, with no react_valid or false_start pulse.

Configuration
REQ-027 Macro F1_FALSE_START_EN defined: react in FILL or HOLD -> false_start pulse, data_out = 0, -> IDLE, react_time unchanged.
REQ-028 Macro F1_FALSE_START_EN undefined: react is ignored outside GO; false_start is tied 0.

Verification
REQ-029 N_LIGHTS=8: rst, trigger, 8 ticks -> data_out 00000001, 00000011 ... 11111111 after each tick; busy = 1.
REQ-030 First run after reset, no react: HOLD lasts exactly LFSR-at-entry ticks (model the LFSR) -> data_out = 0, state GO.
REQ-031 GO: react 25 cycles after lights-out -> react_time = 25, react_valid one cycle, busy = 0 next cycle.
REQ-032 F1_FALSE_START_EN defined: react after the 4th tick -> false_start pulse, data_out = 0, react_time keeps its prior value; undefined -> no effect, sequence completes.
REQ-033 CNT_W=4: react 40 cycles into GO -> react_time = 15 (saturated).
REQ-034 rst asserted in HOLD, then trigger -> clean restart from data_out = 0; no stray pulses; LFSR = 7'h01 at restart.
